// File: rtl/fc_ws_mem_if.sv
// Weight and bias memory read ports of the FC weight streamer.
// Both memories return data one cycle after a read enable.
interface fc_ws_mem_if #(
  parameter int LANES    = 100,
  parameter int W_ADDR_W = 12,
  parameter int B_ADDR_W = 4
);
  logic                  wmem_rd_en_o;
  logic [W_ADDR_W-1:0]   wmem_rd_addr_o;
  logic [LANES*8-1:0]    wmem_rd_data_i;
  logic                  bmem_rd_en_o;
  logic [B_ADDR_W-1:0]   bmem_rd_addr_o;
  logic [LANES*32-1:0]   bmem_rd_data_i;

  modport master (
    output wmem_rd_en_o, wmem_rd_addr_o, bmem_rd_en_o, bmem_rd_addr_o,
    input  wmem_rd_data_i, bmem_rd_data_i
  );

  modport slave (
    input  wmem_rd_en_o, wmem_rd_addr_o, bmem_rd_en_o, bmem_rd_addr_o,
    output wmem_rd_data_i, bmem_rd_data_i
  );
endinterface

// File: rtl/fc_weight_streamer.sv
// Feeds the FC accelerator one batch of LANES neurons at a time: prefetches bias and the first
// weight word, acknowledges the weight request, then streams one int8 weight vector per cycle.
module fc_weight_streamer #(
  parameter int LANES    = 100,
  parameter int W_ADDR_W = 12,
  parameter int B_ADDR_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_async_n_i,
  input  logic                cfg_start_i,
  input  logic [W_ADDR_W-1:0] cfg_w_base_i,
  input  logic [B_ADDR_W-1:0] cfg_b_base_i,
  input  logic [15:0]         cfg_in_len_i,
  input  logic [15:0]         cfg_out_len_i,
  input  logic                weight_req_i,
  output logic                weight_ack_o,
  input  logic                stream_start_i,
  fc_ws_mem_if.master         mem_if,
  output logic signed [7:0]   weights_vector_o [LANES],
  output logic signed [31:0]  bias_vector_o [LANES],
  output logic                busy_o,
  output logic                done_o
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_READY  = 3'd4;
  localparam logic [2:0] S_STREAM = 3'd5;

  logic [2:0]          r_state;
  logic [W_ADDR_W-1:0] r_row_base;
  logic [B_ADDR_W-1:0] r_b_addr;
  logic [15:0]         r_in_len;
  logic [15:0]         r_remain;
  logic [15:0]         r_k;
  logic                r_ack;
  logic                r_done;
  logic signed [7:0]   r_weights [LANES];
  logic signed [31:0]  r_bias [LANES];

  logic                w_handshake;
  logic                w_in_gt1;
  logic                w_more;
  logic                w_last_batch;
  logic                w_end_batch;
  logic [16:0]         w_k2;
  logic [W_ADDR_W-1:0] w_next_addr;
  logic signed [7:0]   w_weights_in [LANES];
  logic signed [31:0]  w_bias_in [LANES];

  assign w_handshake  = r_ack & stream_start_i;
  assign w_in_gt1     = r_in_len > 16'd1;
  assign w_k2         = {1'b0, r_k} + 17'd2;
  assign w_more       = w_k2 < {1'b0, r_in_len};
  assign w_next_addr  = r_row_base + w_k2[W_ADDR_W-1:0];
  assign w_last_batch = r_remain <= 16'(LANES);
  assign w_end_batch  = (r_state == S_READY && w_handshake && !w_in_gt1) ||
                        (r_state == S_STREAM && r_k == r_in_len - 16'd1);

  // r_remain counts neurons not yet covered, so lanes at or above it belong to no neuron.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic w_valid;
    assign w_valid         = r_remain > 16'(j);
    assign w_weights_in[j] = w_valid ? mem_if.wmem_rd_data_i[8*j +: 8] : '0;
    assign w_bias_in[j]    = w_valid ? mem_if.bmem_rd_data_i[32*j +: 32] : '0;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    mem_if.wmem_rd_en_o   = 1'b0;
    mem_if.wmem_rd_addr_o = r_row_base;
    mem_if.bmem_rd_en_o   = 1'b0;
    mem_if.bmem_rd_addr_o = r_b_addr;
    case (r_state)
      S_FETCH: begin
        mem_if.wmem_rd_en_o = 1'b1;
        mem_if.bmem_rd_en_o = 1'b1;
      end
      S_LOAD: begin
        mem_if.wmem_rd_en_o   = w_in_gt1;
        mem_if.wmem_rd_addr_o = r_row_base + W_ADDR_W'(1);
      end
      S_READY: begin
        // Keep v1 on the read bus while waiting, so it is ready the cycle after the handshake.
        if (w_handshake) begin
          mem_if.wmem_rd_en_o   = w_more;
          mem_if.wmem_rd_addr_o = w_next_addr;
        end else begin
          mem_if.wmem_rd_en_o   = w_in_gt1;
          mem_if.wmem_rd_addr_o = r_row_base + W_ADDR_W'(1);
        end
      end
      S_STREAM: begin
        mem_if.wmem_rd_en_o   = w_more;
        mem_if.wmem_rd_addr_o = w_next_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      r_state    <= S_IDLE;
      r_row_base <= '0;
      r_b_addr   <= '0;
      r_in_len   <= '0;
      r_remain   <= '0;
      r_k        <= '0;
      r_ack      <= 1'b0;
      r_done     <= 1'b0;
      // NOTE: these arrays drive outputs directly, so unlike a memory they must be reset.
      for (int j = 0; j < LANES; j++) begin
        r_weights[j] <= '0;
        r_bias[j]    <= '0;
      end
    end else begin
      // NOTE: sequential state is written with non-blocking assignments only.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (cfg_start_i) begin
          r_row_base <= cfg_w_base_i;
          r_b_addr   <= cfg_b_base_i;
          r_in_len   <= cfg_in_len_i;
          r_remain   <= cfg_out_len_i;
          r_state    <= S_ARMED;
        end
        S_ARMED: if (weight_req_i) r_state <= S_FETCH;
        S_FETCH: begin
          r_k     <= '0;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_weights <= w_weights_in;
          r_bias    <= w_bias_in;
          r_ack     <= 1'b1;
          r_state   <= S_READY;
        end
        S_READY: if (w_handshake) begin
          r_ack     <= 1'b0;
          r_k       <= 16'd1;
          r_weights <= w_weights_in;
          r_state   <= S_STREAM;
        end
        S_STREAM: begin
          r_k       <= r_k + 16'd1;
          r_weights <= w_weights_in;
        end
        default: r_state <= S_IDLE;
      endcase

      // Bias is deliberately left alone here: the accelerator still needs it for write-back.
      if (w_end_batch) begin
        for (int j = 0; j < LANES; j++) r_weights[j] <= '0;
        r_row_base <= r_row_base + r_in_len[W_ADDR_W-1:0];
        r_b_addr   <= r_b_addr + B_ADDR_W'(1);
        r_remain   <= r_remain - 16'(LANES);
        r_done     <= w_last_batch;
        r_state    <= w_last_batch ? S_IDLE : S_ARMED;
      end
    end
  end

  assign weight_ack_o     = r_ack;
  assign busy_o           = r_state != S_IDLE;
  assign done_o           = r_done;
  assign weights_vector_o = r_weights;
  assign bias_vector_o    = r_bias;
endmodule

// File: tb/tb_fc_weight_streamer.sv
// Scoreboard bench for fc_weight_streamer: stimulus queues the expected stream per batch,
// a monitor pops and compares one entry per cycle once the handshake is seen.
module tb_fc_weight_streamer;
  localparam int LANES    = 100;
  localparam int W_ADDR_W = 12;
  localparam int B_ADDR_W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_start = 1'b0;
  logic [W_ADDR_W-1:0] cfg_w_base = '0;
  logic [B_ADDR_W-1:0] cfg_b_base = '0;
  logic [15:0]         cfg_in_len = '0;
  logic [15:0]         cfg_out_len = '0;
  logic                weight_req = 1'b0;
  logic                stream_start = 1'b0;
  logic                weight_ack;
  logic                busy;
  logic                done;
  logic signed [7:0]   weights [LANES];
  logic signed [31:0]  bias [LANES];

  fc_ws_mem_if #(.LANES(LANES), .W_ADDR_W(W_ADDR_W), .B_ADDR_W(B_ADDR_W)) mem_if ();

  fc_weight_streamer #(.LANES(LANES), .W_ADDR_W(W_ADDR_W), .B_ADDR_W(B_ADDR_W)) dut (
    .clk_i            (clk),
    .rst_async_n_i    (rst_n),
    .cfg_start_i      (cfg_start),
    .cfg_w_base_i     (cfg_w_base),
    .cfg_b_base_i     (cfg_b_base),
    .cfg_in_len_i     (cfg_in_len),
    .cfg_out_len_i    (cfg_out_len),
    .weight_req_i     (weight_req),
    .weight_ack_o     (weight_ack),
    .stream_start_i   (stream_start),
    .mem_if           (mem_if),
    .weights_vector_o (weights),
    .bias_vector_o    (bias),
    .busy_o           (busy),
    .done_o           (done)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of address and lane.
  function automatic logic [7:0] wbyte(input int a, input int j);
    return 8'((a & 4095) * 7 + j * 13 + 1);
  endfunction

  function automatic logic [31:0] bword(input int a, input int j);
    return 32'((a & 15) * 1000 + j * 3 - 150);
  endfunction

  function automatic logic [LANES*8-1:0] gen_w(input int a);
    logic [LANES*8-1:0] v;
    for (int j = 0; j < LANES; j++) v[8*j +: 8] = wbyte(a, j);
    return v;
  endfunction

  function automatic logic [LANES*32-1:0] gen_b(input int a);
    logic [LANES*32-1:0] v;
    for (int j = 0; j < LANES; j++) v[32*j +: 32] = bword(a, j);
    return v;
  endfunction

  int                  n_wreads;
  int                  n_watch;
  logic [W_ADDR_W-1:0] watch_addr = '1;

  always @(posedge clk) begin
    if (mem_if.wmem_rd_en_o) begin
      mem_if.wmem_rd_data_i <= gen_w(int'(mem_if.wmem_rd_addr_o));
      n_wreads <= n_wreads + 1;
      if (mem_if.wmem_rd_addr_o == watch_addr) n_watch <= n_watch + 1;
    end
    if (mem_if.bmem_rd_en_o) mem_if.bmem_rd_data_i <= gen_b(int'(mem_if.bmem_rd_addr_o));
  end

  typedef struct {
    int addr;
    int valid;
    bit zero;
    bit last;
    bit exp_done;
    int b_addr;
    int b_valid;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_tests;
  int n_fail;
  int cur_b_addr;
  int cur_b_valid;
  bit cur_b_zero = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int w_mismatch(input int addr, input int valid, input bit zero);
    int n = 0;
    for (int j = 0; j < LANES; j++)
      if (weights[j] !== ((zero || j >= valid) ? 8'd0 : wbyte(addr, j))) n++;
    return n;
  endfunction

  function automatic int b_mismatch(input int addr, input int valid, input bit zero);
    int n = 0;
    for (int j = 0; j < LANES; j++)
      if (bias[j] !== ((zero || j >= valid) ? 32'd0 : bword(addr, j))) n++;
    return n;
  endfunction

  initial begin : monitor
    bit active;
    sb_item_t it;
    active = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else begin
        if (!active && weight_ack && stream_start) active = 1'b1;
        if (active) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
            active = 1'b0;
          end else begin
            it = sb_q.pop_front();
            check(it.zero ? "stream_tail_zero" : "stream_vector", w_mismatch(it.addr, it.valid, it.zero), 0);
            check("stream_bias", b_mismatch(it.b_addr, it.b_valid, 1'b0), 0);
            check("stream_done", done, it.exp_done);
            if (it.last) begin
              check("busy_after_batch", busy, !it.exp_done);
              active = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_pulse(input int wb, input int bb, input int il, input int ol);
    cycle();
    cfg_w_base  = W_ADDR_W'(wb);
    cfg_b_base  = B_ADDR_W'(bb);
    cfg_in_len  = 16'(il);
    cfg_out_len = 16'(ol);
    cfg_start   = 1'b1;
    cycle();
    cfg_start   = 1'b0;
  endtask

  task automatic push_batch(input int rb, input int il, input int valid, input int ba, input bit last);
    sb_item_t it;
    for (int k = 0; k < il; k++) begin
      it = '{addr: (rb + k) & 4095, valid: valid, zero: 1'b0, last: 1'b0,
             exp_done: 1'b0, b_addr: ba, b_valid: valid};
      sb_q.push_back(it);
    end
    it = '{addr: 0, valid: valid, zero: 1'b1, last: 1'b1,
           exp_done: last, b_addr: ba, b_valid: valid};
    sb_q.push_back(it);
  endtask

  task automatic do_batch(input int rb, input int ba, input int il, input int valid,
                          input bit last, input int stall);
    int lat;
    cycle();
    weight_req = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!weight_ack && lat < 8) begin
      check("bias_hold_until_load", b_mismatch(cur_b_addr, cur_b_valid, cur_b_zero), 0);
      @(negedge clk);
      lat++;
    end
    check("ack_latency", lat, 3);
    weight_req = 1'b0;
    if (!weight_ack) return;
    cur_b_addr  = ba;
    cur_b_valid = valid;
    cur_b_zero  = 1'b0;
    check("v0_at_ack", w_mismatch(rb, valid, 1'b0), 0);
    for (int s = 0; s < stall; s++) begin
      cycle();
      @(negedge clk);
      check("ack_held", weight_ack, 1);
      check("v0_stable", w_mismatch(rb, valid, 1'b0), 0);
    end
    cycle();
    push_batch(rb, il, valid, ba, last);
    stream_start = 1'b1;
    cycle();
    stream_start = 1'b0;
    @(negedge clk);
    check("ack_drops", weight_ack, 0);
    lat = 1;
    while (sb_q.size() != 0 && lat < il + 8) begin
      @(negedge clk);
      lat++;
    end
    check("stream_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic run_layer(input int wb, input int bb, input int il, input int ol,
                           input int stall, input bit poke);
    int nb;
    int valid;
    cfg_pulse(wb, bb, il, ol);
    nb = (ol + LANES - 1) / LANES;
    for (int b = 0; b < nb; b++) begin
      if (b > 0 && poke) begin
        cycle();
        cfg_w_base  = 12'h555;
        cfg_b_base  = 4'd9;
        cfg_in_len  = 16'd1;
        cfg_out_len = 16'd1;
        cfg_start   = 1'b1;
        cycle();
        cfg_start   = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bias_hold_between", b_mismatch(cur_b_addr, cur_b_valid, cur_b_zero), 0);
          check("weights_zero_between", w_mismatch(0, 0, 1'b1), 0);
          check("busy_between", busy, 1);
          check("ack_low_between", weight_ack, 0);
        end
      end
      valid = ol - b * LANES;
      if (valid > LANES) valid = LANES;
      do_batch((wb + b * il) & 4095, (bb + b) & 15, il, valid, b == nb - 1, stall);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int snap;
    int snap_w;
    int lat;

    repeat (2) @(negedge clk);
    check("rst_weights", w_mismatch(0, 0, 1'b1), 0);
    check("rst_bias", b_mismatch(0, 0, 1'b1), 0);
    check("rst_ack", weight_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wmem_en", mem_if.wmem_rd_en_o, 0);
    cycle();
    rst_n = 1'b1;

    // single batch, ten live lanes
    run_layer(12'h020, 1, 4, 10, 1, 1'b0);

    // three batches, last one half masked, cfg_start poked between batches
    run_layer(12'h100, 2, 3, 250, 1, 1'b1);

    // in_len = 1: row_base+1 must never be read, only the FETCH read happens
    watch_addr = 12'h301;
    snap   = n_watch;
    snap_w = n_wreads;
    run_layer(12'h300, 0, 1, 50, 1, 1'b0);
    check("no_row1_read", n_watch - snap, 0);
    check("in1_read_count", n_wreads - snap_w, 1);

    // long stall in READY, out_len exactly one full batch
    run_layer(12'h040, 5, 5, 100, 20, 1'b0);

    // weight address wraps between batches
    run_layer(12'hFFD, 14, 3, 150, 2, 1'b0);

    // reset in the middle of a stream
    cfg_pulse(12'h200, 3, 8, 10);
    cycle();
    weight_req = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!weight_ack && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("rst_test_ack", weight_ack, 1);
    cycle();
    push_batch(12'h200, 8, 10, 3, 1'b1);
    stream_start = 1'b1;
    cycle();
    stream_start = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b0;
    sb_q.delete();
    cur_b_zero = 1'b1;
    @(negedge clk);
    check("abort_weights", w_mismatch(0, 0, 1'b1), 0);
    check("abort_bias", b_mismatch(0, 0, 1'b1), 0);
    check("abort_ack", weight_ack, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_wmem_en", mem_if.wmem_rd_en_o, 0);
    check("abort_bmem_en", mem_if.bmem_rd_en_o, 0);
    snap_w = n_wreads;
    cycle();
    rst_n = 1'b1;
    stream_start = 1'b1;
    repeat (5) cycle();
    @(negedge clk);
    check("idle_ignores_req_ack", weight_ack, 0);
    check("idle_ignores_req_busy", busy, 0);
    check("no_reads_after_abort", n_wreads - snap_w, 0);
    weight_req = 1'b0;
    stream_start = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
